// File: rtl/red_pitaya_exp_pkg.sv
// red_pitaya_exp_pkg: shared constants for the expansion connector input conditioner
package red_pitaya_exp_pkg;
    localparam int          EXP_DW       = 8;
    localparam int          EXP_CW       = 16;
    // Byte offset of the sticky event flag register in the housekeeping map
    localparam logic [19:0] EXP_FLAG_OFS = 20'h00040;
endpackage

// File: rtl/red_pitaya_exp_deb_if.sv
// red_pitaya_exp_deb_if: pad/control inputs and conditioned outputs of one connector side
interface red_pitaya_exp_deb_if #(
    parameter int DW = red_pitaya_exp_pkg::EXP_DW,
    parameter int CW = red_pitaya_exp_pkg::EXP_CW
);
    logic [DW-1:0] pad_i;
    logic [CW-1:0] len_i;
    logic [DW-1:0] clr_i;
    logic [DW-1:0] dat_o;
    logic [DW-1:0] rise_o;
    logic [DW-1:0] fall_o;
    logic [DW-1:0] flag_o;
    modport master (output pad_i, len_i, clr_i, input dat_o, rise_o, fall_o, flag_o);
    modport slave  (input pad_i, len_i, clr_i, output dat_o, rise_o, fall_o, flag_o);
endinterface

// File: rtl/red_pitaya_deb_bit.sv
// red_pitaya_deb_bit: synchroniser, debounce counter, edge pulses and sticky flag for one pad bit
module red_pitaya_deb_bit #(
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          pad_i,
    input  logic [CW-1:0] len_i,
    input  logic          clr_i,
    output logic          dat_o,
    output logic          rise_o,
    output logic          fall_o,
    output logic          flag_o
);
    logic          s1, s2, acc;
    logic [CW-1:0] cnt;
    // cnt only counts while s2 differs; the >= compare fires before cnt can wrap
    assign acc = (s2 != dat_o) && (cnt >= len_i);
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            dat_o  <= 1'b0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            flag_o <= 1'b0;
        end else begin
            s1     <= pad_i;
            s2     <= s1;
            cnt    <= (s2 == dat_o || acc) ? '0 : cnt + 1'b1;
            dat_o  <= acc ? s2 : dat_o;
            rise_o <= acc & s2;
            fall_o <= acc & ~s2;
            flag_o <= rise_o | fall_o | (flag_o & ~clr_i);
        end
endmodule

// File: rtl/red_pitaya_exp_deb.sv
// red_pitaya_exp_deb: per-bit debounce of one expansion connector side, feeding exp_*_dat_i
module red_pitaya_exp_deb
    import red_pitaya_exp_pkg::*;
#(
    parameter int DW = EXP_DW,
    parameter int CW = EXP_CW
) (
    input logic                  clk_i,
    input logic                  rst_i,
    red_pitaya_exp_deb_if.slave  bus
);
    for (genvar i = 0; i < DW; i++) begin : g_bit
        red_pitaya_deb_bit #(.CW(CW)) u_bit (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .pad_i  (bus.pad_i[i]),
            .len_i  (bus.len_i),
            .clr_i  (bus.clr_i[i]),
            .dat_o  (bus.dat_o[i]),
            .rise_o (bus.rise_o[i]),
            .fall_o (bus.fall_o[i]),
            .flag_o (bus.flag_o[i])
        );
    end
endmodule

// File: tb/tb_red_pitaya_exp_deb.sv
// tb_red_pitaya_exp_deb: directed vectors and corner-case sequences for red_pitaya_exp_deb
module tb_red_pitaya_exp_deb;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   errs = 0;
    int   checks = 0;
    red_pitaya_exp_deb_if #(.DW(8), .CW(16)) bus ();
    red_pitaya_exp_deb #(.DW(8), .CW(16)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
    always #5 clk_i = ~clk_i;
    typedef struct {
        logic [7:0] pad;
        logic [7:0] dat;
        logic [7:0] rise;
        logic [7:0] fall;
    } vec_t;
    vec_t tbl[10];
    task automatic tick(int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic do_reset();
        bus.pad_i = 8'h00;
        bus.clr_i = 8'h00;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask
    task automatic run(int n, int b, output int nr, output int nf, output int tr, output int tf);
        nr = 0; nf = 0; tr = 0; tf = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (bus.rise_o[b]) begin
                nr++;
                if (tr == 0) tr = k;
            end
            if (bus.fall_o[b]) begin
                nf++;
                if (tf == 0) tf = k;
            end
        end
    endtask
    initial begin
        int nr, nf, tr, tf, sr, sf;
        // len_i = 0: dat is the pad value set two rows earlier
        tbl[0] = '{8'hA5, 8'h00, 8'h00, 8'h00};
        tbl[1] = '{8'h3C, 8'h00, 8'h00, 8'h00};
        tbl[2] = '{8'hFF, 8'hA5, 8'hA5, 8'h00};
        tbl[3] = '{8'h00, 8'h3C, 8'h18, 8'h81};
        tbl[4] = '{8'h0F, 8'hFF, 8'hC3, 8'h00};
        tbl[5] = '{8'hF0, 8'h00, 8'h00, 8'hFF};
        tbl[6] = '{8'h96, 8'h0F, 8'h0F, 8'h00};
        tbl[7] = '{8'h96, 8'hF0, 8'hF0, 8'h0F};
        tbl[8] = '{8'h96, 8'h96, 8'h06, 8'h60};
        tbl[9] = '{8'h96, 8'h96, 8'h00, 8'h00};
        bus.pad_i = 8'h00;
        bus.clr_i = 8'h00;
        bus.len_i = 16'd4;
        tick(2);
        rst_i = 1'b0;
        // Reset: async clear of live outputs, then a held-high pad reappears as a rise
        bus.pad_i = 8'hFF;
        tick(9);
        chk("pre_rst_dat", bus.dat_o, 8'hFF);
        chk("pre_rst_flag", bus.flag_o, 8'hFF);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_dat", bus.dat_o, 8'h00);
        chk("rst_rise", bus.rise_o, 8'h00);
        chk("rst_fall", bus.fall_o, 8'h00);
        chk("rst_flag", bus.flag_o, 8'h00);
        tick();
        rst_i = 1'b0;
        tick(6);
        chk("rel_e6_dat", bus.dat_o, 8'h00);
        chk("rel_e6_rise", bus.rise_o, 8'h00);
        tick();
        chk("rel_e7_dat", bus.dat_o, 8'hFF);
        chk("rel_e7_rise", bus.rise_o, 8'hFF);
        chk("rel_e7_flag", bus.flag_o, 8'h00);
        tick();
        chk("rel_e8_rise", bus.rise_o, 8'h00);
        chk("rel_e8_flag", bus.flag_o, 8'hFF);
        chk("rel_e8_dat", bus.dat_o, 8'hFF);
        // Glitch reject (3 cycles) and accept (4 cycles) with len_i = 3
        do_reset();
        bus.len_i = 16'd3;
        bus.pad_i = 8'h01;
        run(3, 0, nr, nf, tr, tf);
        sr = nr;
        bus.pad_i = 8'h00;
        run(10, 0, nr, nf, tr, tf);
        chk("glitch_rej_rise", sr + nr, 0);
        chk("glitch_rej_dat", bus.dat_o, 8'h00);
        bus.pad_i = 8'h01;
        run(4, 0, nr, nf, tr, tf);
        chk("glitch_acc_early", nr, 0);
        bus.pad_i = 8'h00;
        run(10, 0, nr, nf, tr, tf);
        chk("glitch_acc_nrise", nr, 1);
        chk("glitch_acc_trise", tr, 2);
        chk("glitch_acc_nfall", nf, 1);
        chk("glitch_acc_tfall", tf, 6);
        chk("glitch_acc_dat", bus.dat_o, 8'h00);
        // Chatter on bit1 with len_i = 5, then settle high
        do_reset();
        bus.len_i = 16'd5;
        sr = 0; sf = 0;
        for (int j = 0; j < 20; j++) begin
            bus.pad_i = (j % 2 == 0) ? 8'h02 : 8'h00;
            run(2, 1, nr, nf, tr, tf);
            sr += nr; sf += nf;
        end
        chk("chatter_mid_dat", bus.dat_o, 8'h00);
        bus.pad_i = 8'h02;
        run(20, 1, nr, nf, tr, tf);
        chk("chatter_nrise", sr + nr, 1);
        chk("chatter_nfall", sf + nf, 0);
        chk("chatter_dat", bus.dat_o, 8'h02);
        // len_i shrinks from 100 to 10 while cnt sits at 50
        do_reset();
        bus.len_i = 16'd100;
        bus.pad_i = 8'h08;
        run(52, 3, nr, nf, tr, tf);
        chk("shrink_norise", nr, 0);
        chk("shrink_pre_dat", bus.dat_o, 8'h00);
        bus.len_i = 16'd10;
        tick();
        chk("shrink_rise", bus.rise_o, 8'h08);
        chk("shrink_dat", bus.dat_o, 8'h08);
        // Flag set beats a coincident clear; a lone clear affects only its bit
        do_reset();
        bus.len_i = 16'd0;
        bus.pad_i = 8'h24;
        tick(3);
        chk("flag_rise", bus.rise_o, 8'h24);
        chk("flag_pre", bus.flag_o, 8'h00);
        bus.clr_i = 8'h04;
        tick();
        bus.clr_i = 8'h00;
        chk("flag_collide", bus.flag_o, 8'h24);
        bus.clr_i = 8'h04;
        tick();
        bus.clr_i = 8'h00;
        chk("flag_clr", bus.flag_o, 8'h20);
        tick();
        chk("flag_hold", bus.flag_o, 8'h20);
        // Table: len_i = 0, bits independent
        do_reset();
        bus.len_i = 16'd0;
        tick(3);
        for (int i = 0; i < 10; i++) begin
            bus.pad_i = tbl[i].pad;
            tick();
            chk($sformatf("tbl%0d_dat", i), bus.dat_o, tbl[i].dat);
            chk($sformatf("tbl%0d_rise", i), bus.rise_o, tbl[i].rise);
            chk($sformatf("tbl%0d_fall", i), bus.fall_o, tbl[i].fall);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
